// File: rtl/regfile_hilo.sv
// General-purpose register file with two combinational read ports, one write port and a HI/LO pair.
// Zero read latency. Writes land on the rising edge. The block has no backpressure.
module regfile_hilo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address_s1,
    input  logic [ADDR_WIDTH-1:0] address_s2,
    input  logic [ADDR_WIDTH-1:0] address_d,
    input  logic [DATA_WIDTH-1:0] data_dval,
    input  logic                  write_enable,
    input  logic                  hilo_write_enable,
    input  logic [DATA_WIDTH-1:0] hi_in,
    input  logic [DATA_WIDTH-1:0] lo_in,
    output logic [DATA_WIDTH-1:0] data_s1val,
    output logic [DATA_WIDTH-1:0] data_s2val,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  gpr_wr;
    logic                  hilo_wr;

    // Writes to a hardwired r0 are dropped here, so the bypass never sees them either.
    always_comb begin
        gpr_wr  = reset_n && write_enable && !((ZERO_REG != 0) && (address_d == '0));
        hilo_wr = reset_n && hilo_write_enable;
    end

    always_comb begin
        regs_d = regs_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (gpr_wr) begin
            regs_d[address_d] = data_dval;
        end
        if (hilo_wr) begin
            hi_d = hi_in;
            lo_d = lo_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            regs_q <= regs_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    always_comb begin
        data_s1val = regs_q[address_s1];
        if ((BYPASS != 0) && gpr_wr && (address_d == address_s1)) begin
            data_s1val = data_dval;
        end
        if ((ZERO_REG != 0) && (address_s1 == '0)) begin
            data_s1val = '0;
        end
    end

    always_comb begin
        data_s2val = regs_q[address_s2];
        if ((BYPASS != 0) && gpr_wr && (address_d == address_s2)) begin
            data_s2val = data_dval;
        end
        if ((ZERO_REG != 0) && (address_s2 == '0)) begin
            data_s2val = '0;
        end
    end

    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
        if ((BYPASS != 0) && hilo_wr) begin
            hi_out = hi_in;
            lo_out = lo_in;
        end
    end

endmodule
